// File: rtl/draw_rect_char_pkg.sv
// Shared definitions for the character text-box overlay.
//   Glyph geometry, box size in glyphs, colour width, and the packed
//   bundles that travel down the pixel pipeline next to the glyph lookup.
package draw_rect_char_pkg;

  localparam int CHAR_W   = 8;   // glyph width in pixels
  localparam int CHAR_H   = 16;  // glyph height in pixels
  localparam int BOX_COLS = 16;  // glyphs per box row
  localparam int BOX_ROWS = 16;  // glyph rows per box
  localparam int COLOR_W  = 12;  // 4:4:4 RGB

  localparam int BOX_W = CHAR_W * BOX_COLS;  // 128 pixels
  localparam int BOX_H = CHAR_H * BOX_ROWS;  // 256 lines

  // VGA timing bundle carried alongside every pixel.
  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } timing_t;

  // Everything that has to wait for the font ROM before the colour is chosen.
  typedef struct packed {
    timing_t              timing;
    logic [COLOR_W-1:0]   rgb;
    logic                 in_box;
    logic [2:0]           bitsel;
  } pixel_t;

  localparam int PIXEL_W = $bits(pixel_t);

endpackage

// File: rtl/draw_rect_char_delay.sv
// Fixed-depth register delay line with synchronous active-low clear.
//   clk   : clock, rising edge
//   rst_n : synchronous clear, active low (clears every stage)
//   din   : WIDTH-bit input word
//   dout  : din delayed by DEPTH clock edges
module draw_rect_char_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/draw_rect_char.sv
// Text-box overlay: draws a 16x16 grid of 8x16 glyphs at (XPOS, YPOS) on
// top of an incoming VGA pixel stream.
//   pclk                : pixel clock, rising edge
//   rst_n               : synchronous reset, active low
//   hcount_in/vcount_in : current pixel position
//   hsync_in/vsync_in, hblnk_in/vblnk_in : VGA timing
//   rgb_in              : upstream pixel colour
//   char_pixels         : glyph row from the font ROM, MSB = leftmost pixel
//   char_xy             : {row, col} address to the character map
//   char_line           : glyph row index to the font ROM
//   *_out               : timing and composed colour, 3 pclk after input
// Compile option DRAW_RECT_CHAR_BG_EN: glyph-off pixels inside the box show
// BG_COLOR (opaque box) instead of the upstream colour (transparent box).
module draw_rect_char
  import draw_rect_char_pkg::*;
#(
  parameter logic [10:0] XPOS     = 11'd100,
  parameter logic [10:0] YPOS     = 11'd50,
  parameter logic [11:0] FG_COLOR = 12'hFFF,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [7:0]  char_pixels,
  output logic [7:0]  char_xy,
  output logic [3:0]  char_line,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

`ifdef DRAW_RECT_CHAR_BG_EN
  localparam logic BG_EN = 1'b1;
`else
  localparam logic BG_EN = 1'b0;
`endif

  logic [6:0]  h_rel;   // offset inside the box: col[6:3], bit[2:0]
  logic [7:0]  v_rel;   // offset inside the box: row[7:4], line[3:0]
  logic        in_box_c;
  pixel_t      pix_in;
  pixel_t      pix_s2;
  logic [11:0] rgb_c;

  // The box test uses the raw counters, so positions left of / above the box
  // are rejected by comparison; the truncated differences are only used once
  // the pixel is known to be inside.
  always_comb begin
    h_rel    = 7'(hcount_in - XPOS);
    v_rel    = 8'(vcount_in - YPOS);
    in_box_c = (hcount_in >= XPOS) &&
               ({1'b0, hcount_in} < ({1'b0, XPOS} + 12'(BOX_W))) &&
               (vcount_in >= YPOS) &&
               ({1'b0, vcount_in} < ({1'b0, YPOS} + 12'(BOX_H)));
  end

  // Stage 1: glyph address towards the character map / font ROM.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      char_xy   <= 8'h00;
      char_line <= 4'h0;
    end else if (in_box_c) begin
      char_xy   <= {v_rel[7:4], h_rel[6:3]};
      char_line <= v_rel[3:0];
    end else begin
      char_xy   <= 8'h00;
      char_line <= 4'h0;
    end
  end

  always_comb begin
    pix_in               = '0;
    pix_in.timing.hcount = hcount_in;
    pix_in.timing.vcount = vcount_in;
    pix_in.timing.hsync  = hsync_in;
    pix_in.timing.vsync  = vsync_in;
    pix_in.timing.hblnk  = hblnk_in;
    pix_in.timing.vblnk  = vblnk_in;
    pix_in.rgb           = rgb_in;
    pix_in.in_box        = in_box_c;
    pix_in.bitsel        = h_rel[2:0];
  end

  // Stages 1 and 2: the pixel context waits here while the font ROM answers.
  draw_rect_char_delay #(
    .WIDTH (PIXEL_W),
    .DEPTH (2)
  ) u_delay (
    .clk   (pclk),
    .rst_n (rst_n),
    .din   (pix_in),
    .dout  (pix_s2)
  );

  // Colour choice: blanking wins, then glyph foreground, then background or
  // the upstream colour.
  always_comb begin
    rgb_c = pix_s2.rgb;
    if (pix_s2.timing.hblnk || pix_s2.timing.vblnk) begin
      rgb_c = 12'h000;
    end else if (pix_s2.in_box) begin
      if (char_pixels[3'd7 - pix_s2.bitsel]) rgb_c = FG_COLOR;
      else if (BG_EN)                       rgb_c = BG_COLOR;
    end
  end

  // Stage 3: output registers.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= pix_s2.timing.hcount;
      vcount_out <= pix_s2.timing.vcount;
      hsync_out  <= pix_s2.timing.hsync;
      vsync_out  <= pix_s2.timing.vsync;
      hblnk_out  <= pix_s2.timing.hblnk;
      vblnk_out  <= pix_s2.timing.vblnk;
      rgb_out    <= rgb_c;
    end
  end

endmodule

// File: tb/tb_draw_rect_char.sv
// Bench for draw_rect_char: registered font-ROM model, pixel-level model
// with an expected-output queue, directed literal checks and a randomized
// raster/jump stream with random reset pulses.
module tb_draw_rect_char;

  localparam logic [10:0] XPOS = 11'd100;
  localparam logic [10:0] YPOS = 11'd50;
  localparam logic [11:0] FG   = 12'hFFF;
  localparam logic [11:0] BG   = 12'h000;
`ifdef DRAW_RECT_CHAR_BG_EN
  localparam bit BG_EN = 1'b1;
`else
  localparam bit BG_EN = 1'b0;
`endif
  localparam int OW = 38;  // {hcount, vcount, hs, vs, hb, vb, rgb}

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [7:0]  char_pixels = '0;
  logic [7:0]  char_xy;
  logic [3:0]  char_line;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int total = 0;
  int bad   = 0;
  int font_sel = 0;  // 0: hashed font, 1: every row 8'h80, 2: every row 8'hFF

  logic [OW-1:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 pclk = ~pclk;

  draw_rect_char #(
    .XPOS(XPOS), .YPOS(YPOS), .FG_COLOR(FG), .BG_COLOR(BG)
  ) dut (
    .pclk(pclk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .char_pixels(char_pixels),
    .char_xy(char_xy), .char_line(char_line),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  // Glyph content for character code {row, col} and glyph line.
  function automatic logic [7:0] font_byte(int sel, logic [7:0] code, logic [3:0] line);
    logic [15:0] m;
    if (sel == 1) return 8'h80;
    if (sel == 2) return 8'hFF;
    m = 16'(code) * 16'd37 + 16'(line) * 16'd91 + 16'h5A;
    return m[7:0] ^ {line, code[3:0]};
  endfunction

  // Character map + font ROM: ROM registers its address on pclk.
  always @(posedge pclk) char_pixels <= font_byte(font_sel, char_xy, char_line);

  task automatic chk(string name, logic [OW-1:0] act, logic [OW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model + compare (every cycle) ----------------
  always @(posedge pclk) begin
    int hx, vy, bitn;
    logic inb, pix;
    logic [7:0] code, glyph, exp_xy;
    logic [3:0] line, exp_line;
    logic [11:0] col;
    logic [OW-1:0] e, got;
    hx = int'(hcount_in) - int'(XPOS);
    vy = int'(vcount_in) - int'(YPOS);
    inb = (hx >= 0) && (hx < 128) && (vy >= 0) && (vy < 256);
    code = '0; line = '0; pix = 1'b0; bitn = 0;
    if (inb) begin
      code  = 8'((vy / 16) * 16 + (hx / 8));
      line  = 4'(vy % 16);
      bitn  = hx % 8;
      glyph = font_byte(font_sel, code, line);
      pix   = glyph[7 - bitn];
    end
    if (hblnk_in || vblnk_in)  col = 12'h000;
    else if (inb && pix)       col = FG;
    else if (inb && BG_EN)     col = BG;
    else                       col = rgb_in;
    e = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, col};
    exp_xy   = code;
    exp_line = line;
    if (!rst_n) begin
      // reset discards everything in flight
      foreach (exp_q[i]) exp_q[i] = '0;
      e = '0; exp_xy = '0; exp_line = '0;
    end
    exp_q.push_back(e);
    #1;
    chk("char_xy", OW'(char_xy), OW'(exp_xy));
    chk("char_line", OW'(char_line), OW'(exp_line));
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      got = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
      chk("timing_out", OW'(got[OW-1:12]), OW'(e[OW-1:12]));
      chk("rgb_out", OW'(rgb_out), OW'(e[11:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(logic [10:0] h, logic [10:0] v, logic hs, logic vs,
                       logic hb, logic vb, logic [11:0] rgb);
    @(negedge pclk);
    hcount_in = h; vcount_in = v; hsync_in = hs; vsync_in = vs;
    hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
  endtask

  task automatic do_reset(int sel);
    @(negedge pclk);
    rst_n = 1'b0;
    font_sel = sel;
    @(posedge pclk); #1;
    chk("rst_rgb", OW'(rgb_out), OW'(0));
    chk("rst_hcount", OW'(hcount_out), OW'(0));
    chk("rst_xy", OW'(char_xy), OW'(0));
    @(negedge pclk);
    rst_n = 1'b1;
  endtask

  // Hold one pixel, check the glyph address one edge later and the colour
  // and syncs three edges after sampling.
  task automatic lit(string nm, logic [10:0] h, logic [10:0] v, logic hs, logic vs,
                     logic hb, logic [11:0] rgb, logic [7:0] exy, logic [3:0] eline,
                     logic [11:0] ergb);
    drive(h, v, hs, vs, hb, 1'b0, rgb);
    @(posedge pclk); #1;
    chk({nm, "_xy"}, OW'(char_xy), OW'(exy));
    chk({nm, "_line"}, OW'(char_line), OW'(eline));
    @(posedge pclk);
    @(posedge pclk); #1;
    chk({nm, "_rgb"}, OW'(rgb_out), OW'(ergb));
    chk({nm, "_sync"}, OW'({hsync_out, vsync_out}), OW'({hs, vs}));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [10:0] h, v;
    repeat (3) @(posedge pclk);

    do_reset(1);  // every glyph row = 1000_0000
    lit("origin", 11'd100, 11'd50, 1'b0, 1'b0, 1'b0, 12'h0F0, 8'h00, 4'h0, 12'hFFF);
    lit("second_px", 11'd101, 11'd50, 1'b1, 1'b0, 1'b0, 12'h0F0, 8'h00, 4'h0,
        BG_EN ? 12'h000 : 12'h0F0);

    do_reset(2);  // every glyph row = 1111_1111
    lit("left_out", 11'd99, 11'd50, 1'b1, 1'b1, 1'b0, 12'hABC, 8'h00, 4'h0, 12'hABC);
    lit("corner", 11'd227, 11'd305, 1'b0, 1'b1, 1'b0, 12'h123, 8'hFF, 4'hF, 12'hFFF);
    lit("right_out", 11'd228, 11'd305, 1'b1, 1'b0, 1'b0, 12'h456, 8'h00, 4'h0, 12'h456);
    lit("bottom_out", 11'd150, 11'd306, 1'b0, 1'b0, 1'b0, 12'h321, 8'h00, 4'h0, 12'h321);
    lit("hblank", 11'd150, 11'd100, 1'b0, 1'b0, 1'b1, 12'h789, 8'h36, 4'h2, 12'h000);

    do_reset(0);  // hashed font for the random stream
    h = 11'd90; v = 11'd60;
    for (int n = 0; n < 4000; n++) begin
      h = h + 11'd1;
      if (h > 11'd240) begin
        h = 11'($urandom_range(85, 110));
        v = 11'($urandom_range(35, 320));
      end
      @(negedge pclk);
      if ($urandom_range(0, 7) == 0) begin
        hcount_in = 11'($urandom_range(0, 2047));
        vcount_in = 11'($urandom_range(0, 2047));
      end else begin
        hcount_in = h;
        vcount_in = v;
      end
      hsync_in = 1'($urandom_range(0, 1));
      vsync_in = 1'($urandom_range(0, 1));
      hblnk_in = ($urandom_range(0, 15) == 0);
      vblnk_in = ($urandom_range(0, 15) == 0);
      rgb_in   = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 99) < 3) begin
        rst_n = 1'b0;
        font_sel = ($urandom_range(0, 3) == 0) ? 2 : 0;
      end else begin
        rst_n = 1'b1;
      end
    end

    @(negedge pclk);
    rst_n = 1'b1;
    repeat (4) @(negedge pclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/draw_rect_char.md
DRAW_RECT_CHAR -- requirements
Module: draw_rect_char

Interface
REQ-001 Parameter XPOS, default 11'd100: left edge of text box, pixels.
REQ-002 Parameter YPOS, default 11'd50: top edge of text box, pixels.
REQ-003 Parameter FG_COLOR, default 12'hFFF: glyph pixel colour.
REQ-004 Parameter BG_COLOR, default 12'h000: box background colour (used only with the macro in REQ-029).
REQ-005 pclk  in  1: pixel clock, all logic on rising edge.
REQ-006 rst_n  in  1: reset, synchronous, active-low.
REQ-007 hcount_in, vcount_in  in  11 each: current pixel position.
REQ-008 hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each: VGA timing.
REQ-009 rgb_in  in  12: upstream pixel colour.
REQ-010 char_pixels  in  8: glyph row from font ROM; MSB is the leftmost pixel.
REQ-011 char_xy  out  8: {row[3:0], col[3:0]} request to the 16x16 character map.
REQ-012 char_line  out  4: glyph row index to font ROM.
REQ-013 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  out  (same widths as inputs): delayed timing and composed colour.

Function
REQ-014 Box SHALL span 128x256 pixels: XPOS <= hcount_in < XPOS+128 and YPOS <= vcount_in < YPOS+256 (16 columns x 16 rows of 8x16 glyphs).
REQ-015 Stage 1 (edge t+1): SHALL register char_xy = {(vcount_in-YPOS)[7:4], (hcount_in-XPOS)[6:3]}, char_line = (vcount_in-YPOS)[3:0], in_box flag, bit select = (hcount_in-XPOS)[2:0], plus all timing inputs and rgb_in.
REQ-016 Outside the box, char_xy and char_line SHALL be registered as 8'h00 and 4'h0.
REQ-017 Character map is combinational; font ROM registers its address on pclk, so char_pixels SHALL be treated as valid at the t+2 cycle for the pixel sampled at t.
REQ-018 Stage 2 (edge t+2): SHALL delay in_box, bit select, timing and rgb by one more register.
REQ-019 Stage 3 (edge t+3): rgb_out SHALL be FG_COLOR when in_box and char_pixels[7-bitsel]=1; otherwise per REQ-029; timing outputs SHALL be the stage-2 values.
REQ-020 Total latency from any input to the matching output SHALL be exactly 3 pclk cycles for every signal.
REQ-021 Blanking override: if hblnk or vblnk (delayed) is 1, rgb_out SHALL be 12'h000 regardless of box content.
REQ-022 Subtractions SHALL be 11-bit unsigned; positions below XPOS/YPOS SHALL be excluded by the comparison, not by wrap-around of the difference.
REQ-023 Box edges: hcount_in = XPOS+127 SHALL be in box (col 15, bitsel 7); XPOS+128 SHALL not.

Reset
REQ-024 While rst_n=0 at a rising edge, all pipeline registers and all outputs SHALL become 0.
REQ-025 Reset asserted mid-line SHALL discard in-flight pixels; no partial glyph SHALL appear after release.
REQ-026 After rst_n returns to 1, the first valid output SHALL appear at the 3rd rising edge; earlier outputs SHALL stay 0.

Configuration
REQ-027 Exactly one compile option: macro DRAW_RECT_CHAR_BG_EN.
REQ-028 Without it: in-box pixels with glyph bit 0 SHALL pass the delayed rgb_in (transparent box).
REQ-029 With it: in-box pixels with glyph bit 0 SHALL output BG_COLOR (opaque box); out-of-box pixels unchanged.

Structure
REQ-030 Shared package SHALL hold: CHAR_W=8, CHAR_H=16, BOX_COLS=16, BOX_ROWS=16, timing-bundle typedef (hcount, vcount, syncs, blanks), colour width 12.
REQ-031 One sub-module, delay (parameterised width and depth, synchronous active-low clear), SHALL implement the timing/rgb delay line.

Verification
REQ-032 hcount_in=100, vcount_in=50 -> one cycle later char_xy=8'h00, char_line=4'h0.
REQ-033 hcount_in=227, vcount_in=305 -> char_xy=8'hFF, char_line=4'hF; hcount_in=228 -> in_box=0, char_xy=8'h00.
REQ-034 char_pixels=8'b1000_0000, rgb_in=12'h0F0, hcount_in=100/101 in box -> rgb_out 12'hFFF then 12'h0F0 (12'h000 with DRAW_RECT_CHAR_BG_EN), 3 cycles later.
REQ-035 hcount_in=99, rgb_in=12'hABC, char_pixels=8'hFF -> rgb_out=12'hABC after 3 cycles; hsync/vsync outputs equal inputs delayed 3.
REQ-036 hblnk_in=1 inside box with char_pixels=8'hFF -> rgb_out=12'h000.
REQ-037 rst_n=0 for one edge mid-glyph -> all outputs 0 for that edge and following 2 edges, then correct pixel stream resumes.
